timer_counter: RTL and testbench

Memory-mapped down-counter peripheral on the data bus, directly downstream of the store byte-enable/address-check stage. One instance is mapped at TC0 (0x7F00–0x7F0B) and one at TC1 (0x7F10–0x7F1B). The bridge decodes the base address and delivers word-aligned, full-word stores; the upstream stage has already faulted sub-word and COUNT-register stores. The block counts down from a preset, raises an interrupt request toward CP0, and supports one-shot and auto-reload modes.

---
 rtl/databus_pkg.sv | 30 +++
 rtl/timer_counter.sv | 128 ++++++++++++
 tb/tb_timer_counter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/databus_pkg.sv
// Shared data-bus definitions for the timer_counter peripheral: FSM states,
// CTRL register layout, register offsets and mode encodings.
package databus;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Only 01 selects auto-reload; both 1x encodings behave as one-shot.
  function automatic logic is_auto_reload(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a
// maskable level interrupt toward CP0.
module timer_counter
  import databus::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e   r_state;
  tc_state_e   w_state_nxt;
  ctrl_t       r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;
  logic        r_irq_flag;
  logic        w_flag_set;
  logic        w_flag_clr;
  logic        w_en_clr;
  logic        w_wr_full;
  logic        w_wr_ctrl;
  logic        w_wr_preset;

  assign w_wr_full   = we && (byteen == 4'b1111);
  assign w_wr_ctrl   = w_wr_full && (addr == OFS_CTRL);
  assign w_wr_preset = w_wr_full && (addr == OFS_PRESET);

  // Next state, next count and the FSM's requests on EN / irq_flag
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_flag_set  = 1'b0;
    w_flag_clr  = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl.en) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_ctrl.en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          w_count_nxt = 32'd0;
          w_flag_set  = 1'b1;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (is_auto_reload(r_ctrl.mode)) begin
          w_flag_clr = 1'b1;
        end else begin
          w_en_clr = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and COUNT register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Bus-visible CTRL/PRESET and irq_flag; a CTRL write beats FSM updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl     <= ctrl_t'(wdata[3:0]);
        r_irq_flag <= 1'b0;
      end else begin
        if (w_en_clr) begin
          r_ctrl.en <= 1'b0;
        end
        if (w_flag_set) begin
          r_irq_flag <= 1'b1;
        end else if (w_flag_clr) begin
          r_irq_flag <= 1'b0;
        end
      end
      if (w_wr_preset) begin
        r_preset <= wdata;
      end
    end
  end

  // Side-effect-free read mux
  always_comb begin
    rdata = 32'd0;
    case (addr)
      OFS_CTRL:   rdata = {28'd0, r_ctrl};
      OFS_PRESET: rdata = r_preset;
      OFS_COUNT:  rdata = r_count;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = r_ctrl.im & r_irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed vector table, hand-written
// corner sequences and a randomized run against a timeline reference model.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  timer_counter dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: registers plus a run timeline (edges since enable seen)
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  logic        m_run;
  int          m_e;
  logic [31:0] m_P;

  task automatic model_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
    m_run = 1'b0; m_e = 0; m_P = 32'd0;
  endtask

  task automatic model_step();
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count, n_P;
    logic        n_flag, n_run;
    int          n_e;
    longint      ex;
    n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_P = m_P;
    n_flag = m_flag; n_run = m_run; n_e = m_e;
    if (!m_run) begin
      if (m_ctrl[0]) begin
        n_run = 1'b1;
        n_e   = 1;
      end
    end else begin
      n_e = m_e + 1;
      // expiry edge: E(P+2) counted from the enable edge, P<=1 behaves as 1
      ex = (m_P <= 32'd1) ? 64'sd3 : longint'(m_P) + 64'sd2;
      if (n_e == 2) begin
        n_P = m_preset;
        n_count = m_preset;
      end else if (n_e <= ex) begin
        if (!m_ctrl[0]) begin
          n_run = 1'b0;
        end else begin
          n_count = (longint'(m_P) > longint'(n_e - 2)) ? m_P - 32'(n_e - 2) : 32'd0;
          if (n_e == ex) n_flag = 1'b1;
        end
      end else begin
        n_run = 1'b0;
        if (m_ctrl[2:1] == 2'b01) n_flag = 1'b0;
        else n_ctrl[0] = 1'b0;
      end
    end
    if (we && byteen == 4'hF) begin
      if (addr == 2'd0) begin
        n_ctrl = wdata[3:0];
        n_flag = 1'b0;
      end else if (addr == 2'd1) begin
        n_preset = wdata;
      end
    end
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_P = n_P;
    m_flag = n_flag; m_run = n_run; m_e = n_e;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [1:0] a, input logic [3:0] be,
                     input logic [31:0] d);
    we = w; addr = a; byteen = be; wdata = d;
    @(posedge clk);
    model_step();
    #1;
    we = 1'b0; byteen = 4'd0;
  endtask

  task automatic nop();
    cyc(1'b0, 2'd0, 4'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [1:0]  ra;
    logic [31:0] er;
    logic        ei;
  } vec_t;

  vec_t tbl[22];
  int   seq[6];

  initial begin
    logic [31:0] v;
    we = 1'b0; addr = 2'd0; byteen = 4'd0; wdata = 32'd0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      chk($sformatf("reset_rdata_a%0d", i), v, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // one-shot P=5, then masked run with P=2, then ignored writes
    tbl[0]  = '{1'b1, 2'd1, 4'hF, 32'd5,      2'd1, 32'd5, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 4'hF, 32'h9,      2'd0, 32'h9, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd5, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd4, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd3, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd2, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd0, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd0, 32'h8, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd0, 1'b1};
    tbl[11] = '{1'b1, 2'd0, 4'hF, 32'h0,      2'd0, 32'h0, 1'b0};
    tbl[12] = '{1'b1, 2'd1, 4'hF, 32'd2,      2'd1, 32'd2, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 4'hF, 32'h1,      2'd0, 32'h1, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd0, 1'b0};
    tbl[15] = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd2, 1'b0};
    tbl[16] = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd1, 1'b0};
    tbl[17] = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd2, 32'd0, 1'b0};
    tbl[18] = '{1'b0, 2'd0, 4'h0, 32'd0,      2'd0, 32'h0, 1'b0};
    tbl[19] = '{1'b1, 2'd2, 4'hF, 32'hFFFF,   2'd2, 32'd0, 1'b0};
    tbl[20] = '{1'b1, 2'd1, 4'h3, 32'h77,     2'd1, 32'd2, 1'b0};
    tbl[21] = '{1'b1, 2'd3, 4'hF, 32'hFFFFFFFF, 2'd3, 32'd0, 1'b0};
    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d);
      rd(tbl[i].ra, v);
      chk($sformatf("vec%0d_rdata", i), v, tbl[i].er);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].ei});
    end

    // auto-reload P=3: COUNT 3,2,1,0,0,0 repeating, irq one cycle in six
    seq = '{3, 2, 1, 0, 0, 0};
    cyc(1'b1, 2'd1, 4'hF, 32'd3);
    cyc(1'b1, 2'd0, 4'hF, 32'hB);
    nop();
    for (int k = 2; k < 14; k++) begin
      nop();
      rd(2'd2, v);
      chk($sformatf("auto_count_E%0d", k), v, 32'(seq[(k - 2) % 6]));
      chk($sformatf("auto_irq_E%0d", k), {31'd0, irq}, ((k - 2) % 6 == 3) ? 32'd1 : 32'd0);
    end
    cyc(1'b1, 2'd0, 4'hF, 32'h0);
    repeat (3) nop();

    // pause at COUNT=10: the write edge still decrements, then it freezes
    cyc(1'b1, 2'd1, 4'hF, 32'd20);
    cyc(1'b1, 2'd0, 4'hF, 32'h1);
    repeat (12) nop();
    rd(2'd2, v);
    chk("pause_count10", v, 32'd10);
    cyc(1'b1, 2'd0, 4'hF, 32'h0);
    repeat (4) nop();
    rd(2'd2, v);
    chk("pause_frozen", v, 32'd9);
    cyc(1'b1, 2'd0, 4'hF, 32'h1);
    nop();
    rd(2'd2, v);
    chk("resume_load_cycle", v, 32'd9);
    nop();
    rd(2'd2, v);
    chk("resume_reloaded", v, 32'd20);
    cyc(1'b1, 2'd0, 4'hF, 32'h0);
    repeat (3) nop();

    // collision: CTRL write on the one-shot INT edge keeps EN and clears flag
    cyc(1'b1, 2'd1, 4'hF, 32'd2);
    cyc(1'b1, 2'd0, 4'hF, 32'h9);
    repeat (4) nop();
    chk("coll_irq_raised", {31'd0, irq}, 32'd1);
    cyc(1'b1, 2'd0, 4'hF, 32'h9);
    rd(2'd0, v);
    chk("coll_ctrl", v, 32'h9);
    chk("coll_irq_cleared", {31'd0, irq}, 32'd0);
    nop();
    nop();
    rd(2'd2, v);
    chk("coll_rerun_count", v, 32'd2);
    cyc(1'b1, 2'd0, 4'hF, 32'h0);
    repeat (3) nop();

    // asynchronous reset mid-count, observed before any further clock edge
    cyc(1'b1, 2'd1, 4'hF, 32'h20);
    cyc(1'b1, 2'd0, 4'hF, 32'h9);
    nop();
    nop();
    rd(2'd2, v);
    chk("pre_reset_count", v, 32'h20);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      rd(2'(i), v);
      chk($sformatf("async_reset_a%0d", i), v, 32'd0);
    end
    chk("async_reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nop();
    rd(2'd2, v);
    chk("post_reset_idle_count", v, 32'd0);

    // randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] ra;
      r = $urandom_range(0, 15);
      if (r < 2)
        cyc(1'b1, 2'd0, 4'hF, {$urandom} & 32'hF);
      else if (r == 2)
        cyc(1'b1, 2'd1, 4'hF, 32'($urandom_range(0, 8)));
      else if (r == 3)
        cyc(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 14)), $urandom);
      else if (r == 4)
        cyc(1'b1, 2'($urandom_range(2, 3)), 4'hF, $urandom);
      else
        nop();
      ra = 2'($urandom_range(0, 3));
      rd(ra, v);
      chk($sformatf("rand%0d_rdata_a%0d", n, ra), v, model_read(ra));
      chk($sformatf("rand%0d_irq", n), {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
